vreg_group_collector: RTL

// - Assembles a vector register group (1/2/4/8 regs of VLEN bits) from a narrow BEAT_W result stream.
// - Sits directly upstream of get_vreg_dpic and drives its enable, rf_addr_in and data_0_in..data_7_in.
// - Fires one enable pulse per completed group so the DPI dump is called exactly once per writeback.

---
 rtl/vreg_collect_pkg.sv | 25 ++
 rtl/vreg_seg_buf.sv | 41 ++++
 rtl/vreg_group_collector.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vreg_collect_pkg.sv
// Shared types and helpers for the vector register group collector.
// Optional beat_last checking is built only when VREG_COLLECT_CHK_EN is defined.
package vreg_collect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam int NREG_MAX = 8;

    function automatic int calc_bpr(input int vlen, input int beat_w);
        return vlen / beat_w;
    endfunction

    function automatic int idx_w(input int bpr);
        return (bpr > 1) ? $clog2(bpr) : 1;
    endfunction

    function automatic logic nreg_legal(input logic [3:0] n);
        return (n == 4'd1) || (n == 4'd2) || (n == 4'd4) || (n == 4'd8);
    endfunction

endpackage

// File: rtl/vreg_seg_buf.sv
// One VLEN-bit vector register segment: synchronous clear and
// BEAT_W-wide slice write at a beat index.
module vreg_seg_buf
    import vreg_collect_pkg::*;
#(
    parameter int VLEN   = 2048,
    parameter int BEAT_W = 256,
    parameter int IDXW   = idx_w(calc_bpr(VLEN, BEAT_W))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [IDXW-1:0]   idx_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [VLEN-1:0]   q_o
);

    logic [VLEN-1:0] q_q;
    logic [VLEN-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (we_i) begin
            q_d[int'(idx_i)*BEAT_W +: BEAT_W] = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/vreg_group_collector.sv
// Collects a 1/2/4/8-register vector group from a narrow beat stream and
// pulses vreg_en once per completed group. Option: VREG_COLLECT_CHK_EN.
module vreg_group_collector
    import vreg_collect_pkg::*;
#(
    parameter int VLEN   = 2048,
    parameter int BEAT_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_addr,
    input  logic [3:0]        cmd_nreg,
    input  logic              beat_valid,
    output logic              beat_ready,
    input  logic [BEAT_W-1:0] beat_data,
    input  logic              beat_last,
    input  logic              abort,
    output logic              err,
    output logic              vreg_en,
    output logic [7:0]        vreg_addr,
    output logic [VLEN-1:0]   vreg_data_0,
    output logic [VLEN-1:0]   vreg_data_1,
    output logic [VLEN-1:0]   vreg_data_2,
    output logic [VLEN-1:0]   vreg_data_3,
    output logic [VLEN-1:0]   vreg_data_4,
    output logic [VLEN-1:0]   vreg_data_5,
    output logic [VLEN-1:0]   vreg_data_6,
    output logic [VLEN-1:0]   vreg_data_7
);

    localparam int BPR  = calc_bpr(VLEN, BEAT_W);
    localparam int IDXW = idx_w(BPR);

    state_e          state_q, state_d;
    logic            live_q;
    logic [7:0]      addr_q, addr_d;
    logic [3:0]      nreg_q, nreg_d;
    logic [2:0]      seg_q, seg_d;
    logic [IDXW-1:0] beat_q, beat_d;
    logic            err_q, err_d;

    logic            hdr_fire;
    logic            hdr_ok;
    logic            beat_fire;
    logic            last_beat;
    logic            chk_bad;
    logic [VLEN-1:0] seg_data [NREG_MAX];

    assign hdr_fire  = cmd_valid & cmd_ready;
    assign hdr_ok    = hdr_fire & nreg_legal(cmd_nreg);
    assign beat_fire = beat_valid & beat_ready;
    assign last_beat = ({1'b0, seg_q} == (nreg_q - 4'd1))
                     && (beat_q == IDXW'(BPR - 1));

`ifdef VREG_COLLECT_CHK_EN
    assign chk_bad = beat_fire & (beat_last != last_beat);

    always @(posedge clk) begin
        if (rst_n && hdr_fire) begin
            assert (nreg_legal(cmd_nreg))
            else $error("vreg_group_collector: illegal cmd_nreg %0d", cmd_nreg);
        end
    end
`else
    logic unused_beat_last;
    assign unused_beat_last = beat_last;
    assign chk_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hdr_ok) state_d = FILL;
            FILL: begin
                if (abort || chk_bad) begin
                    state_d = IDLE;
                end else if (beat_fire && last_beat) begin
                    state_d = EMIT;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready waits for live_q so every output reads 0 while in reset
    always_comb begin
        cmd_ready  = live_q && (state_q == IDLE);
        beat_ready = (state_q == FILL) && !abort;
        vreg_en    = (state_q == EMIT);
        err        = err_q;
    end

    always_comb begin
        addr_d = addr_q;
        nreg_d = nreg_q;
        seg_d  = seg_q;
        beat_d = beat_q;
        err_d  = 1'b0;
        if (hdr_fire && !hdr_ok) begin
            err_d = 1'b1;
        end
        if (hdr_ok) begin
            addr_d = cmd_addr;
            nreg_d = cmd_nreg;
            seg_d  = 3'd0;
            beat_d = '0;
        end
        if (chk_bad) begin
            err_d = 1'b1;
        end else if (beat_fire) begin
            if (beat_q == IDXW'(BPR - 1)) begin
                beat_d = '0;
                seg_d  = seg_q + 3'd1;
            end else begin
                beat_d = beat_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            addr_q <= '0;
            nreg_q <= '0;
            seg_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            addr_q <= addr_d;
            nreg_q <= nreg_d;
            seg_q  <= seg_d;
            beat_q <= beat_d;
            err_q  <= err_d;
        end
    end

    for (genvar k = 0; k < NREG_MAX; k++) begin : g_seg
        vreg_seg_buf #(
            .VLEN   (VLEN),
            .BEAT_W (BEAT_W),
            .IDXW   (IDXW)
        ) u_seg (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (hdr_ok),
            .we_i   (beat_fire && !chk_bad && (seg_q == 3'(k))),
            .idx_i  (beat_q),
            .data_i (beat_data),
            .q_o    (seg_data[k])
        );
    end

    assign vreg_addr   = addr_q;
    assign vreg_data_0 = seg_data[0];
    assign vreg_data_1 = seg_data[1];
    assign vreg_data_2 = seg_data[2];
    assign vreg_data_3 = seg_data[3];
    assign vreg_data_4 = seg_data[4];
    assign vreg_data_5 = seg_data[5];
    assign vreg_data_6 = seg_data[6];
    assign vreg_data_7 = seg_data[7];

endmodule
